// File: rtl/cla_seq_ctrl_if.sv
// Request/grant and result bus for cla_seq_ctrl, plus the wires to the shared
// 16-bit adder. The slave side is the sequencer; the master side is whatever
// sits around it (two requesters and the adder instance).
interface cla_seq_ctrl_if;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic        sub0, sub1;
    logic        wide0, wide1;
    logic        sign0, sign1;
    logic        gnt0, gnt1;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [31:0] result;
    logic        ofl, cout;
    logic [15:0] add_a, add_b;
    logic        add_ci, add_sign;
    logic [15:0] add_sum;
    logic        add_ofl, add_cout;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, sub0, sub1, wide0, wide1, sign0, sign1,
        input  add_sum, add_ofl, add_cout,
        output gnt0, gnt1, busy, done, done_id, result, ofl, cout,
        output add_a, add_b, add_ci, add_sign
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, sub0, sub1, wide0, wide1, sign0, sign1,
        output add_sum, add_ofl, add_cout,
        input  gnt0, gnt1, busy, done, done_id, result, ofl, cout,
        input  add_a, add_b, add_ci, add_sign
    );
endinterface

// File: rtl/cla_seq_ctrl.sv
// Round-robin sequencer for one shared 16-bit CLA. Narrow ops take one adder
// pass (LO); wide ops take LO then HI with the LO carry chained into HI.
// Results and flags are registered and announced with a one-cycle done pulse.
module cla_seq_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    cla_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        wide;
        logic        sign;
        logic        id;
    } op_t;

    state_t      state, nstate;
    op_t         op;
    logic        last;       // port granted most recently (1 at reset so port 0 wins first)
    logic        pick;       // port chosen this cycle
    logic        grant;
    logic        gnt0, gnt1;
    logic [15:0] lo_sum;
    logic        lo_carry;
    logic [31:0] result;
    logic        ofl, cout, done, done_id;
    logic [15:0] add_a, add_b;
    logic        add_ci, add_sign;

    // Arbiter: only in IDLE and never while reset is held, at most one grant.
    always_comb begin
        pick  = 1'b0;
        grant = 1'b0;
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        if (state == IDLE && rst_n) begin
            pick  = (bus.req0 && bus.req1) ? ~last : bus.req1;
            grant = bus.req0 | bus.req1;
            gnt0  = grant & ~pick;
            gnt1  = grant & pick;
        end
    end

    // Next-state: a grant starts LO; wide ops continue into HI.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (grant) nstate = LO;
            LO:      nstate = op.wide ? HI : IDLE;
            HI:      nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Adder drive: subtraction is A + ~B + 1; HI takes its carry from LO.
    always_comb begin
        add_a    = 16'h0;
        add_b    = 16'h0;
        add_ci   = 1'b0;
        add_sign = 1'b0;
        case (state)
            LO: begin
                add_a    = op.a[15:0];
                add_b    = op.sub ? ~op.b[15:0] : op.b[15:0];
                add_ci   = op.sub;
                add_sign = op.sign & ~op.wide;
            end
            HI: begin
                add_a    = op.a[31:16];
                add_b    = op.sub ? ~op.b[31:16] : op.b[31:16];
                add_ci   = lo_carry;
                add_sign = op.sign;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Latch the granted request so later operand changes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op   <= '0;
            last <= 1'b1;
        end else if (grant) begin
            last <= pick;
            if (pick) op <= '{a: bus.a1, b: bus.b1, sub: bus.sub1, wide: bus.wide1, sign: bus.sign1, id: 1'b1};
            else      op <= '{a: bus.a0, b: bus.b0, sub: bus.sub0, wide: bus.wide0, sign: bus.sign0, id: 1'b0};
        end
    end

    // Result capture; the low half of a wide op is staged so result only
    // changes on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_sum   <= 16'h0;
            lo_carry <= 1'b0;
            result   <= 32'h0;
            ofl      <= 1'b0;
            cout     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LO: begin
                    lo_sum   <= bus.add_sum;
                    lo_carry <= bus.add_cout;
                    if (!op.wide) begin
                        result  <= {16'h0, bus.add_sum};
                        ofl     <= bus.add_ofl;
                        cout    <= bus.add_cout;
                        done    <= 1'b1;
                        done_id <= op.id;
                    end
                end
                HI: begin
                    result  <= {bus.add_sum, lo_sum};
                    ofl     <= bus.add_ofl;
                    cout    <= bus.add_cout;
                    done    <= 1'b1;
                    done_id <= op.id;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done;
    assign bus.done_id  = done_id;
    assign bus.result   = result;
    assign bus.ofl      = ofl;
    assign bus.cout     = cout;
    assign bus.add_a    = add_a;
    assign bus.add_b    = add_b;
    assign bus.add_ci   = add_ci;
    assign bus.add_sign = add_sign;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Bench for cla_seq_ctrl: behavioural 16-bit adder on the adder wires and an
// arithmetic reference model for the expected 16/32-bit results and flags.
module tb_cla_seq_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    cla_seq_ctrl_if bus ();

    cla_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared adder stand-in: 16-bit add with carry, signed or unsigned overflow.
    logic [16:0] am_full;
    assign am_full      = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'h0, bus.add_ci};
    assign bus.add_sum  = am_full[15:0];
    assign bus.add_cout = am_full[16];
    assign bus.add_ofl  = bus.add_sign ? ((bus.add_a[15] == bus.add_b[15]) && (am_full[15] != bus.add_a[15]))
                                       : am_full[16];

    // Reference: plain integer arithmetic at 16 or 32 bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  input logic wide, input logic sign,
                                  output logic [31:0] r, output logic o, output logic c);
        longint ua, ub, sa, sb, ur, sr, lim;
        if (wide) begin
            ua = longint'(a); ub = longint'(b);
            sa = longint'($signed(a)); sb = longint'($signed(b));
            lim = longint'(1) << 32;
        end else begin
            ua = longint'(a[15:0]); ub = longint'(b[15:0]);
            sa = longint'($signed(a[15:0])); sb = longint'($signed(b[15:0]));
            lim = longint'(1) << 16;
        end
        if (sub) begin
            ur = ua - ub; sr = sa - sb; c = (ua >= ub);
        end else begin
            ur = ua + ub; sr = sa + sb; c = (ur >= lim);
        end
        r = wide ? ur[31:0] : {16'h0, ur[15:0]};
        o = sign ? ((sr >= lim / 2) || (sr < -(lim / 2))) : c;
    endfunction

    task automatic do_reset();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", bus.result); end
        n_checks++; if ({bus.ofl, bus.cout, bus.done, bus.done_id, bus.busy} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 00000", {bus.ofl, bus.cout, bus.done, bus.done_id, bus.busy}); end
        n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b exp 00", {bus.gnt0, bus.gnt1}); end
        n_checks++; if ({bus.add_a, bus.add_b, bus.add_ci, bus.add_sign} !== 34'h0) begin n_fail++; $display("FAIL reset_adder got %h exp 0", {bus.add_a, bus.add_b, bus.add_ci, bus.add_sign}); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One complete operation on one port; operands are scrambled right after
    // the grant so the result must come from the sampled values.
    task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic wide, input logic sign, input string nm);
        logic [31:0] er; logic eo, ec, g, go;
        logic [16:0] lo;
        int n;
        model(a, b, sub, wide, sign, er, eo, ec);
        lo = {1'b0, a[15:0]} + {1'b0, sub ? ~b[15:0] : b[15:0]} + {16'h0, sub};
        @(negedge clk);
        if (port == 0) begin bus.a0 = a; bus.b0 = b; bus.sub0 = sub; bus.wide0 = wide; bus.sign0 = sign; bus.req0 = 1'b1; end
        else           begin bus.a1 = a; bus.b1 = b; bus.sub1 = sub; bus.wide1 = wide; bus.sign1 = sign; bus.req1 = 1'b1; end
        n = 0;
        #1;
        g = (port == 0) ? bus.gnt0 : bus.gnt1;
        while (!g && n < 20) begin
            @(negedge clk); n++;
            g = (port == 0) ? bus.gnt0 : bus.gnt1;
        end
        n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL %s grant_timeout got %b exp 1", nm, g); bus.req0 = 0; bus.req1 = 0; return; end
        go = (port == 0) ? bus.gnt1 : bus.gnt0;
        n_checks++; if (go !== 1'b0) begin n_fail++; $display("FAIL %s other_gnt got %b exp 0", nm, go); end
        @(negedge clk);  // LO
        if (port == 0) begin bus.req0 = 1'b0; bus.a0 = ~a; bus.b0 = a ^ b; bus.sub0 = ~sub; bus.wide0 = ~wide; bus.sign0 = ~sign; end
        else           begin bus.req1 = 1'b0; bus.a1 = ~a; bus.b1 = a ^ b; bus.sub1 = ~sub; bus.wide1 = ~wide; bus.sign1 = ~sign; end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s lo_busy got %b exp 1", nm, bus.busy); end
        n_checks++; if ({bus.add_a, bus.add_ci, bus.add_sign} !== {a[15:0], sub, sign & ~wide}) begin n_fail++; $display("FAIL %s lo_drive got %h exp %h", nm, {bus.add_a, bus.add_ci, bus.add_sign}, {a[15:0], sub, sign & ~wide}); end
        if (wide) begin
            @(negedge clk);  // HI
            n_checks++; if ({bus.add_a, bus.add_ci, bus.add_sign} !== {a[31:16], lo[16], sign}) begin n_fail++; $display("FAIL %s hi_drive got %h exp %h", nm, {bus.add_a, bus.add_ci, bus.add_sign}, {a[31:16], lo[16], sign}); end
        end
        @(negedge clk);  // completion cycle
        n_checks++; if ({bus.done, bus.done_id, bus.busy} !== {1'b1, port[0], 1'b0}) begin n_fail++; $display("FAIL %s done got %b exp %b", nm, {bus.done, bus.done_id, bus.busy}, {1'b1, port[0], 1'b0}); end
        n_checks++; if ({bus.result, bus.ofl, bus.cout} !== {er, eo, ec}) begin n_fail++; $display("FAIL %s result got %h/%b%b exp %h/%b%b", nm, bus.result, bus.ofl, bus.cout, er, eo, ec); end
        @(negedge clk);
        n_checks++; if ({bus.done, bus.result, bus.ofl, bus.cout} !== {1'b0, er, eo, ec}) begin n_fail++; $display("FAIL %s hold got %b/%h exp 0/%h", nm, bus.done, bus.result, er); end
    endtask

    task automatic test_directed();
        run_op(0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, "narrow_signed_add");
        run_op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, "wide_unsigned_add");
        run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, "wide_signed_sub");
    endtask

    task automatic test_operand_stability();
        run_op(0, 32'h1234_5678, 32'h0000_1111, 1'b0, 1'b1, 1'b0, "operand_stability");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            run_op(int'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), "random");
    endtask

    // Both ports request narrow ops continuously after reset.
    task automatic test_back_to_back();
        logic [31:0] er0, er1, er; logic eo0, ec0, eo1, ec1, eo, ec;
        int ng, lastc, p;
        do_reset();
        bus.a0 = $urandom; bus.b0 = $urandom; bus.sub0 = 1'($urandom); bus.sign0 = 1'($urandom); bus.wide0 = 1'b0;
        bus.a1 = $urandom; bus.b1 = $urandom; bus.sub1 = 1'($urandom); bus.sign1 = 1'($urandom); bus.wide1 = 1'b0;
        model(bus.a0, bus.b0, bus.sub0, 1'b0, bus.sign0, er0, eo0, ec0);
        model(bus.a1, bus.b1, bus.sub1, 1'b0, bus.sign1, er1, eo1, ec1);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        ng = 0; lastc = 0;
        for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
            #1;
            n_checks++; if (bus.gnt0 && bus.gnt1) begin n_fail++; $display("FAIL b2b_both_gnt got 11 exp one-hot"); end
            if (bus.done) begin
                er = bus.done_id ? er1 : er0; eo = bus.done_id ? eo1 : eo0; ec = bus.done_id ? ec1 : ec0;
                n_checks++; if ({bus.result, bus.ofl, bus.cout} !== {er, eo, ec}) begin n_fail++; $display("FAIL b2b_result got %h exp %h", bus.result, er); end
            end
            if (bus.gnt0 || bus.gnt1) begin
                p = bus.gnt1 ? 1 : 0;
                n_checks++; if (p != ng % 2) begin n_fail++; $display("FAIL b2b_order got %0d exp %0d", p, ng % 2); end
                if (ng > 0) begin
                    n_checks++; if (cyc - lastc != 2 || bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_spacing got %0d/%b exp 2/1", cyc - lastc, bus.done); end
                end
                lastc = cyc; ng++;
            end
            @(negedge clk);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        n_checks++; if (ng != 4) begin n_fail++; $display("FAIL b2b_grants got %0d exp 4", ng); end
        repeat (3) @(negedge clk);
    endtask

    // Reset lands in the HI cycle of a wide op; req0 stays up throughout.
    task automatic test_reset_mid();
        logic [31:0] er; logic eo, ec;
        int n, seen;
        do_reset();
        bus.a0 = $urandom; bus.b0 = $urandom; bus.sub0 = 1'b0; bus.sign0 = 1'b0; bus.wide0 = 1'b1; bus.req0 = 1'b1;
        model(bus.a0, bus.b0, 1'b0, 1'b1, 1'b0, er, eo, ec);
        n = 0;
        #1;
        while (!bus.gnt0 && n < 20) begin @(negedge clk); #1; n++; end
        n_checks++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant got %b exp 1", bus.gnt0); end
        repeat (2) @(negedge clk);  // HI
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_hi got %b exp 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.result, bus.ofl, bus.cout, bus.busy, bus.done, bus.gnt0} !== 37'h0) begin n_fail++; $display("FAIL rstmid_clear got %h/%b%b%b%b%b exp 0", bus.result, bus.ofl, bus.cout, bus.busy, bus.done, bus.gnt0); end
        seen = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.done) seen++; end
        rst_n = 1'b1;
        #1;
        n_checks++; if ({bus.gnt0, seen[0]} !== 2'b10) begin n_fail++; $display("FAIL rstmid_regrant got gnt0=%b done_seen=%0d exp 1/0", bus.gnt0, seen); end
        @(negedge clk); bus.req0 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({bus.done, bus.result, bus.ofl, bus.cout} !== {1'b1, er, eo, ec}) begin n_fail++; $display("FAIL rstmid_result got %b/%h exp 1/%h", bus.done, bus.result, er); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        bus.req0 = 0; bus.req1 = 0;
        bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
        bus.sub0 = 0; bus.sub1 = 0; bus.wide0 = 0; bus.wide1 = 0; bus.sign0 = 0; bus.sign1 = 0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_operand_stability();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
